// File: rtl/rr_muxnv.sv
// Round-robin N-channel arbitrating mux with a one-entry registered output stage.
// Define RR_MUXNV_LOCK_EN to add in_last and hold a grant until the end of each packet.
module rr_muxnv #(
    parameter int width    = 32,
    parameter int channels = 4,
    localparam int sel_w   = $clog2(channels)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [channels*width-1:0] in_data,
    input  logic [channels-1:0]       in_valid,
`ifdef RR_MUXNV_LOCK_EN
    input  logic [channels-1:0]       in_last,
`endif
    output logic [channels-1:0]       in_ready,
    output logic [width-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [sel_w-1:0]          out_sel
);

    logic [sel_w-1:0] ptr;
    logic [sel_w-1:0] grant;
    logic             gnt_any;
    logic             can_load;
    logic             accept;
`ifdef RR_MUXNV_LOCK_EN
    logic             lock;
`endif

    assign can_load = ~out_valid | out_ready;
    assign accept   = gnt_any & can_load;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin : grant_search
        int  idx;
        logic found;
        grant   = '0;
        found   = 1'b0;
        gnt_any = |in_valid;
        for (int k = 1; k <= channels; k++) begin
            idx = (int'(ptr) + k) % channels;
            if (!found && in_valid[idx]) begin
                grant = sel_w'(idx);
                found = 1'b1;
            end
        end
`ifdef RR_MUXNV_LOCK_EN
        // Every accept also loads ptr, so while locked ptr already names the owning channel.
        if (lock) begin
            grant   = ptr;
            gnt_any = in_valid[ptr];
        end
`endif
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < channels; i++) begin
            in_ready[i] = accept && (grant == sel_w'(i));
        end
    end

    // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= sel_w'(channels - 1);
`ifdef RR_MUXNV_LOCK_EN
            lock      <= 1'b0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(grant)*width +: width];
            out_sel   <= grant;
            ptr       <= grant;
`ifdef RR_MUXNV_LOCK_EN
            lock      <= ~in_last[grant];
`endif
        end else if (out_ready) begin
            // Consumer took the word and nothing replaces it; data and index keep their last value.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_muxnv.sv
// Self-checking bench for rr_muxnv: directed scenarios plus randomized traffic against a
// cycle-level reference model. Build with RR_MUXNV_LOCK_EN to also exercise packet locking.
module tb_rr_muxnv;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 2;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [SW-1:0]  out_sel;
`ifdef RR_MUXNV_LOCK_EN
    logic [N-1:0]   in_last = '0;
`endif

    always #5 clock = ~clock;

    rr_muxnv #(.width(W), .channels(N)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .in_valid (in_valid),
`ifdef RR_MUXNV_LOCK_EN
        .in_last  (in_last),
`endif
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sel  (out_sel)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the output register contents and whose turn it is, as plain integers.
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_sel;
    int           m_last_winner;
    bit           m_lock;
    int           m_lock_ch;

    task automatic model_reset();
        m_valid       = 1'b0;
        m_data        = '0;
        m_sel         = 0;
        m_last_winner = N - 1;
        m_lock        = 1'b0;
        m_lock_ch     = 0;
    endtask

    // Winner: first valid channel after the last winner, wrapping; -1 when none can win.
    function automatic int pick();
        if (m_lock) return in_valid[m_lock_ch] ? m_lock_ch : -1;
        for (int k = 1; k <= N; k++) begin
            if (in_valid[(m_last_winner + k) % N]) return (m_last_winner + k) % N;
        end
        return -1;
    endfunction

    // Called at a falling edge with inputs already driven: check, clock, advance model.
    task automatic cycle(input string tag);
        int           g;
        bit           can;
        logic [N-1:0] exp_rdy;
        #1;
        g       = pick();
        can     = !m_valid || out_ready;
        exp_rdy = '0;
        if (g >= 0 && can) exp_rdy[g] = 1'b1;
        check({tag, " in_ready"}, 64'(in_ready), 64'(exp_rdy));
        check({tag, " out_valid"}, 64'(out_valid), 64'(m_valid));
        check({tag, " out_data"}, 64'(out_data), 64'(m_data));
        check({tag, " out_sel"}, 64'(out_sel), 64'(m_sel));
        @(posedge clock);
        if (g >= 0 && can) begin
            m_valid       = 1'b1;
            m_data        = in_data[g*W +: W];
            m_sel         = g;
            m_last_winner = g;
`ifdef RR_MUXNV_LOCK_EN
            m_lock    = !in_last[g];
            m_lock_ch = g;
`endif
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 5; i++) cycle("idle");
        check("idle out_data", 64'(out_data), 64'h0);

        // Single channel
        in_valid = 4'b0100;
        in_data[2*W +: W] = 32'hDEADBEEF;
        out_ready = 1'b1;
        #1 check("single in_ready", 64'(in_ready), 64'b0100);
        cycle("single");
        in_valid = '0;
        check("single out_valid", 64'(out_valid), 64'h1);
        check("single out_data", 64'(out_data), 64'hDEADBEEF);
        check("single out_sel", 64'(out_sel), 64'h2);
        cycle("single drain");
        check("single drained", 64'(out_valid), 64'h0);

        // Round robin from a fresh pointer
        do_reset();
        in_valid = 4'b1111;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(i + 1);
        for (int i = 0; i < 8; i++) begin
            cycle("rr");
            check("rr out_sel", 64'(out_sel), 64'(i % N));
            check("rr out_data", 64'(out_data), 64'((i % N) + 1));
        end

        // Reset between edges discards the word at once
        #2 reset_n = 1'b0;
        #1 check("async reset out_valid", 64'(out_valid), 64'h0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        in_valid = 4'b1010;
        cycle("post reset");
        check("post reset out_sel", 64'(out_sel), 64'h1);

        // Backpressure
        do_reset();
        in_valid = 4'b0010;
        in_data[1*W +: W] = 32'h55;
        cycle("bp load");
        in_valid = 4'b1111;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 check("bp stall in_ready", 64'(in_ready), 64'h0);
            cycle("bp stall");
            check("bp hold data", 64'(out_data), 64'h55);
            check("bp hold sel", 64'(out_sel), 64'h1);
        end
        out_ready = 1'b1;
        #1 check("bp release in_ready", 64'(in_ready), 64'b0100);
        cycle("bp release");
        check("bp next sel", 64'(out_sel), 64'h2);

`ifdef RR_MUXNV_LOCK_EN
        // Channel 3 packet of three words while the others compete
        do_reset();
        in_valid = 4'b1000;
        in_last = 4'b0000;
        cycle("lock w0");
        check("lock w0 sel", 64'(out_sel), 64'h3);
        in_valid = 4'b1111;
        cycle("lock w1");
        check("lock w1 sel", 64'(out_sel), 64'h3);
        in_valid = 4'b0111;
        for (int i = 0; i < 2; i++) begin
            #1 check("lock gap in_ready", 64'(in_ready), 64'h0);
            cycle("lock gap");
        end
        in_valid = 4'b1111;
        in_last = 4'b1000;
        cycle("lock w2");
        check("lock w2 sel", 64'(out_sel), 64'h3);
        in_last = 4'b0001;
        cycle("lock after");
        check("lock after sel", 64'(out_sel), 64'h0);
        in_last = '0;
`endif

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            in_valid = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++) in_data[c*W +: W] = $urandom;
`ifdef RR_MUXNV_LOCK_EN
            in_last = N'($urandom);
`endif
            if ($urandom_range(0, 299) == 0) begin
                #2 reset_n = 1'b0;
                #1 check("rand async reset", 64'(out_valid), 64'h0);
                model_reset();
                @(negedge clock);
                reset_n = 1'b1;
            end
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_muxnv.md
Name: rr_muxnv

Overview:
- Parametrised N-channel arbitrating multiplexer with a registered output, used where several producers share one downstream consumer (e.g. writeback or memory-request funnels).
- Selects among `channels` inputs of `width` bits each using round-robin arbitration.
- Valid/ready handshake on every input and on the output.
- Holds the selected word in a one-entry output register, so output timing is decoupled from input mux depth.

Parameters:
- width, 32, data bits per channel
- channels, 4, number of input channels; legal range 2..16
- sel_w, $clog2(channels), width of the channel-index output (derived, not overridden)

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_data  input  channels*width  flattened inputs; channel i at bits [i*width +: width]
- in_valid  input  channels  per-channel valid
- in_ready  output  channels  per-channel ready; at most one bit high in any cycle
- out_data  output  width  registered selected word
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts out_data this cycle
- out_sel  output  sel_w  index of the channel that produced out_data

Behaviour:
- Reset (async assert, sync deassert at the next clock edge):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=channels-1, so channel 0 has the highest priority first.
- Load condition: can_load = ~out_valid | out_ready.
- Grant (combinational):
  - Search in_valid starting at index (ptr+1) mod channels, then increasing with wrap.
  - The first valid channel found is grant; gnt_any=|in_valid.
- in_ready[i] = gnt_any & (i==grant) & can_load.
  - in_ready is 0 for every channel when nothing is valid.
  - in_ready does not depend on in_data.
- Accept: when gnt_any & can_load, at the clock edge:
  - out_data <= in_data[grant]
  - out_sel <= grant
  - out_valid <= 1
  - ptr <= grant
- Latency: a word accepted in cycle t appears on out_data/out_valid in cycle t+1.
- Drain: out_valid & out_ready & ~gnt_any -> out_valid <= 0. out_data and out_sel hold their last value.
- Simultaneous drain and accept: the old word is consumed and the new word is loaded in the same edge. Full throughput is 1 word per cycle with no bubble.
- Stall: out_valid & ~out_ready:
  - out_data, out_sel and out_valid are held stable.
  - All in_ready=0.
  - ptr is unchanged.
- Fairness: with all channels continuously valid and out_ready=1, the grant sequence is 0,1,...,channels-1,0,... A channel waits at most channels-1 accepts.
- The pointer advances only on an actual accept, never on stall or idle cycles.
- Input valid rule: in_valid may drop without a handshake; the arbiter re-evaluates every cycle.
- reset_n asserted mid-transfer: the word in the output register is discarded immediately (out_valid=0 asynchronously).

Optional Feature:
- Macro RR_MUXNV_LOCK_EN adds input port in_last (channels bits, per-channel end-of-packet marker) and an internal lock flag.
- With the macro defined:
  - After accepting a word from channel g with in_last[g]=0, lock=1 and grant is forced to g.
  - While locked, other channels get in_ready=0 even if g is not valid.
  - An accept with in_last[g]=1 clears lock and sets ptr<=g.
  - Reset clears lock.
- Without the macro:
  - The in_last port does not exist.
  - Every accept is treated as in_last=1, so arbitration is per-word.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, then in_valid=0 -> out_valid=0, out_data=0, out_sel=0, in_ready=0000 for 5 cycles.
- Single channel: in_valid=0100, in_data[2]=32'hDEADBEEF, out_ready=1 -> in_ready=0100 in cycle t; out_valid=1, out_data=DEADBEEF, out_sel=2 in t+1; out_valid=0 in t+2.
- Round robin: in_valid=1111, data[i]=i+1, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with out_valid=1 every cycle after the first.
- Backpressure: load channel 1 (data 0x55), hold out_ready=0 for 4 cycles with in_valid=1111 -> out_data stays 0x55, out_sel=1, in_ready=0000. On the first out_ready=1 cycle, in_ready=0100 and the next out_sel=2.
- Reset mid-stream: during the round-robin test, assert reset_n=0 between clock edges -> out_valid falls immediately. After release with in_valid=1010, the first grant is channel 1.
- LOCK_EN build: channel 3 sends 3 words with in_last=0,0,1 while channels 0-2 are also valid -> out_sel=3,3,3, then 0. Dropping in_valid[3] mid-packet yields in_ready=0000 until channel 3 resumes.
